// File: rtl/joystick_cmd_sched.sv
// Joystick command scheduler: direction auto-repeat, rate-limited fire, one-entry valid/ready command port.
// Optional: define JOYSTICK_FIRE_AUTOREPEAT_EN to re-fire every COOLDOWN_CYC cycles while fire is held.
module joystick_cmd_sched #(
    parameter int DELAY_CYC    = 12000000,
    parameter int REPEAT_CYC   = 3000000,
    parameter int COOLDOWN_CYC = 6000000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [2:0] o_cmd,
    output logic       o_cooldown
);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_FIRE  = 3'd5;

    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LD = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOLDOWN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       dir_q, dir_n, sel_dir;
    logic             step;

    logic [2:0]       move_dir;
    logic             move_pend, fire_pend;
    logic             fire_prev, fire_take;
    logic [CNT_W-1:0] cool;

    logic             load, take_fire, take_move;

    always_comb begin
        if (i_up)         sel_dir = CMD_UP;
        else if (i_down)  sel_dir = CMD_DOWN;
        else if (i_left)  sel_dir = CMD_LEFT;
        else if (i_right) sel_dir = CMD_RIGHT;
        else              sel_dir = CMD_NONE;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir_q;
        step    = 1'b0;
        if (sel_dir == CMD_NONE) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else if (state == S_IDLE || sel_dir != dir_q) begin
            dir_n   = sel_dir;
            step    = 1'b1;
            cnt_n   = DELAY_LD;
            state_n = S_HOLD;
        end else if (cnt == '0) begin
            step    = 1'b1;
            cnt_n   = REPEAT_LD;
            state_n = S_REPEAT;
        end else begin
            cnt_n   = cnt - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_q <= CMD_NONE;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
        end
    end

`ifdef JOYSTICK_FIRE_AUTOREPEAT_EN
    // Armed only by an accepted fire, so a button held through reset stays silent.
    logic fire_arm;
    assign fire_take = (cool == '0) && i_fire && (!fire_prev || fire_arm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  fire_arm <= 1'b0;
        else         fire_arm <= i_fire && (fire_arm || fire_take);
    end
`else
    assign fire_take = (cool == '0) && i_fire && !fire_prev;
`endif

    assign o_cooldown = (cool != '0);

    assign load      = !o_valid || i_ready;
    assign take_fire = load && fire_pend;
    assign take_move = load && !fire_pend && move_pend;

    // A new event wins over a same-cycle consume: the output register took the old flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_prev <= 1'b1;
            cool      <= '0;
            fire_pend <= 1'b0;
            move_pend <= 1'b0;
            move_dir  <= CMD_NONE;
        end else begin
            fire_prev <= i_fire;
            if (fire_take)         cool <= COOL_LD;
            else if (cool != '0)   cool <= cool - 1'b1;
            fire_pend <= fire_take || (fire_pend && !take_fire);
            move_pend <= step || (move_pend && !take_move);
            if (step) move_dir <= dir_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_cmd   <= CMD_NONE;
        end else if (load) begin
            if (fire_pend) begin
                o_valid <= 1'b1;
                o_cmd   <= CMD_FIRE;
            end else if (move_pend) begin
                o_valid <= 1'b1;
                o_cmd   <= move_dir;
            end else begin
                o_valid <= 1'b0;
                o_cmd   <= CMD_NONE;
            end
        end
    end

endmodule

// File: tb/tb_joystick_cmd_sched.sv
// Scoreboard bench for joystick_cmd_sched; expectations are hand-derived cycle/cmd pairs.
// Honours JOYSTICK_FIRE_AUTOREPEAT_EN for the held-fire vector.
module tb_joystick_cmd_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_up, i_down, i_left, i_right, i_fire, i_ready;
    logic       o_valid;
    logic [2:0] o_cmd;
    logic       o_cooldown;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] cmd;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    joystick_cmd_sched #(
        .DELAY_CYC   (8),
        .REPEAT_CYC  (4),
        .COOLDOWN_CYC(5),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_up      (i_up),
        .i_down    (i_down),
        .i_left    (i_left),
        .i_right   (i_right),
        .i_fire    (i_fire),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_cmd     (o_cmd),
        .o_cooldown(o_cooldown)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic expect_cmd(input logic [2:0] c, input int at);
        exp_t e;
        e.cmd = c;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops on each accepted transfer, checks stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd: got cmd=%0d at cycle %0d, required no output", o_cmd, cyc);
            end else if (i_ready) begin
                e = exp_q.pop_front();
                if (o_cmd !== e.cmd || cyc != e.at) begin
                    n_bad++;
                    $display("FAIL transfer: got cmd=%0d at cycle %0d, required cmd=%0d at cycle %0d",
                             o_cmd, cyc, e.cmd, e.at);
                end
            end else if (o_cmd !== exp_q[0].cmd) begin
                n_bad++;
                $display("FAIL stall_hold: got cmd=%0d at cycle %0d, required cmd=%0d", o_cmd, cyc, exp_q[0].cmd);
            end
        end
    end

    initial begin
        int   b;
        logic [6:0] fire_pat  = 7'b0100101;
        logic [6:0] cool_want = 7'b1011110;

        rst_n = 1'b0;
        {i_up, i_down, i_left, i_right, i_fire} = '0;
        i_ready = 1'b1;
        tick(3);
        check("reset_valid", int'(o_valid), 0);
        check("reset_cmd", int'(o_cmd), 0);
        check("reset_cooldown", int'(o_cooldown), 0);
        rst_n = 1'b1;
        tick(2);

        // Hold left: first step, then repeats after 8 and every 4.
        b = cyc;
        i_left = 1'b1;
        expect_cmd(3'd3, b + 2);
        expect_cmd(3'd3, b + 10);
        expect_cmd(3'd3, b + 14);
        expect_cmd(3'd3, b + 18);
        tick(20);
        i_left = 1'b0;
        tick(15);
        drain("hold_left_drained");

        // Priority: up beats right; dropping up yields right, then its repeat.
        b = cyc;
        i_up = 1'b1;
        i_right = 1'b1;
        expect_cmd(3'd1, b + 2);
        expect_cmd(3'd4, b + 6);
        expect_cmd(3'd4, b + 14);
        tick(4);
        i_up = 1'b0;
        tick(11);
        i_right = 1'b0;
        tick(15);
        drain("priority_drained");

        // Fire edges at rel edges 1, 3, 6: the middle one falls inside cooldown.
        b = cyc;
        expect_cmd(3'd5, b + 2);
        expect_cmd(3'd5, b + 7);
        for (int k = 0; k < 7; k++) begin
            i_fire = fire_pat[k];
            @(negedge clk);
            check("cooldown_flag", int'(o_cooldown), int'(cool_want[k]));
            tick(1);
        end
        i_fire = 1'b0;
        tick(10);
        drain("fire_drained");

        // Backpressure: down held with consumer stalled, fire edge during the stall.
        b = cyc;
        i_ready = 1'b0;
        i_down = 1'b1;
        expect_cmd(3'd2, b + 12);
        expect_cmd(3'd5, b + 13);
        expect_cmd(3'd2, b + 14);
        tick(2);
        i_fire = 1'b1;
        tick(1);
        i_fire = 1'b0;
        tick(9);
        i_ready = 1'b1;
        tick(2);
        i_down = 1'b0;
        tick(10);
        drain("backpressure_drained");

        // Reset mid-HOLD with a stalled command, then release with fire held.
        b = cyc;
        i_ready = 1'b0;
        i_left = 1'b1;
        expect_cmd(3'd3, b + 2);
        tick(4);
        check("pre_reset_valid", int'(o_valid), 1);
        rst_n = 1'b0;
        i_fire = 1'b1;
        exp_q.delete();
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_cmd", int'(o_cmd), 0);
        check("rst_cooldown", int'(o_cooldown), 0);
        i_left = 1'b0;
        i_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("held_fire_no_cooldown", int'(o_cooldown), 0);
        check("held_fire_no_valid", int'(o_valid), 0);
        i_fire = 1'b0;
        tick(5);

        // Held fire: one shot, or one per cooldown period with autorepeat.
        b = cyc;
        i_fire = 1'b1;
        expect_cmd(3'd5, b + 2);
`ifdef JOYSTICK_FIRE_AUTOREPEAT_EN
        expect_cmd(3'd5, b + 7);
        expect_cmd(3'd5, b + 12);
`endif
        tick(15);
        i_fire = 1'b0;
        tick(10);
        drain("held_fire_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
